// File: rtl/pinmux_in_pkg.sv
// Shared types and constants for the pinmux pad-input path: filter modes,
// debounce FSM states and the prescaler tick mask helper.
package pinmux_in_pkg;

  typedef enum logic [1:0] {
    FILT_BYPASS = 2'b00,
    FILT_2S     = 2'b01,
    FILT_3S     = 2'b10,
    FILT_DEB    = 2'b11
  } filt_mode_e;

  typedef enum logic {
    STABLE = 1'b0,
    COUNT  = 1'b1
  } deb_state_e;

  localparam int PRESC_WIDTH = 6;

  // A tick fires when the prescaler's low 2*sel bits are all ones.
  function automatic logic [PRESC_WIDTH-1:0] tick_mask(input logic [1:0] sel);
    logic [PRESC_WIDTH-1:0] m;
    case (sel)
      2'd0:    m = 6'h00;
      2'd1:    m = 6'h03;
      2'd2:    m = 6'h0F;
      default: m = 6'h3F;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pinmux_in_sync.sv
// Multi-flop synchronizer for the raw pad level, with a synchronous clear
// used when the input path is disabled.
module pinmux_in_sync
  import pinmux_in_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] chain_p0;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      chain_p0 <= '0;
    end else begin
      chain_p0 <= {chain_p0[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = chain_p0[SYNC_STAGES-1];

endmodule

// File: rtl/pinmux_input_filter_demux.sv
// Pad-to-peripheral input path: synchronizer, glitch filter / debounce, edge
// events and per-function demux. Optional input inversion: PINMUX_IN_INVERT_EN.
module pinmux_input_filter_demux
  import pinmux_in_pkg::*;
#(
  parameter int O_NUM_PERIPHERALS = 4,
  parameter int SYNC_STAGES       = 2,
  parameter int DEB_CNT_WIDTH     = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_pad_in,
  input  logic                         i_ie,
  input  logic [1:0]                   i_filt_mode,
  input  logic [1:0]                   i_deb_clk_sel,
  input  logic [DEB_CNT_WIDTH-1:0]     i_deb_thresh,
  input  logic [O_NUM_PERIPHERALS-1:0] i_infunc_en,
  input  logic [O_NUM_PERIPHERALS-1:0] i_safeval,
`ifdef PINMUX_IN_INVERT_EN
  input  logic                         i_invert,
`endif
  output logic [O_NUM_PERIPHERALS-1:0] o_peripheral_in,
  output logic                         o_gpio_in,
  output logic                         o_rise_evt,
  output logic                         o_fall_evt,
  output logic                         o_filt_busy
);

  localparam logic [DEB_CNT_WIDTH-1:0] CNT_ONE = 1;

  logic                     sync_raw_p0;
  logic                     sync_p0;
  logic                     sync_d1_p1;
  logic                     sync_d2_p2;
  logic                     filt_q;
  logic                     filt_q_d;
  logic [1:0]               mode_q;
  logic [PRESC_WIDTH-1:0]   presc;
  logic [DEB_CNT_WIDTH-1:0] cnt;
  logic [DEB_CNT_WIDTH-1:0] cnt_nxt;
  logic [DEB_CNT_WIDTH-1:0] thresh_m1;
  deb_state_e               state;
  deb_state_e               state_nxt;
  filt_mode_e               mode;
  logic                     filt_nxt;
  logic                     tick;
  logic                     mode_chg;

  pinmux_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_clr(~i_ie),
    .i_d  (i_pad_in & i_ie),
    .o_q  (sync_raw_p0)
  );

`ifdef PINMUX_IN_INVERT_EN
  logic inv_q;
  assign sync_p0  = sync_raw_p0 ^ i_invert;
  assign mode_chg = (i_filt_mode != mode_q) || (i_invert != inv_q);

  always_ff @(posedge i_clk) begin
    if (i_rst) inv_q <= 1'b0;
    else       inv_q <= i_invert;
  end
`else
  assign sync_p0  = sync_raw_p0;
  assign mode_chg = (i_filt_mode != mode_q);
`endif

  assign mode      = filt_mode_e'(i_filt_mode);
  assign tick      = &(presc | ~tick_mask(i_deb_clk_sel));
  assign thresh_m1 = (i_deb_thresh == '0) ? '0 : (i_deb_thresh - CNT_ONE);

  // Next filter value, debounce state and count; a mode change only parks the FSM.
  always_comb begin
    filt_nxt  = filt_q;
    state_nxt = state;
    cnt_nxt   = cnt;
    if (mode_chg) begin
      state_nxt = STABLE;
      cnt_nxt   = '0;
    end else begin
      case (mode)
        FILT_BYPASS: begin
          filt_nxt  = sync_p0;
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end
        FILT_2S: begin
          if (sync_p0 == sync_d1_p1) filt_nxt = sync_p0;
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end
        FILT_3S: begin
          if ((sync_p0 == sync_d1_p1) && (sync_d1_p1 == sync_d2_p2)) filt_nxt = sync_p0;
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end
        FILT_DEB: begin
          case (state)
            STABLE: begin
              if (sync_p0 != filt_q) begin
                state_nxt = COUNT;
                cnt_nxt   = '0;
              end
            end
            COUNT: begin
              if (sync_p0 == filt_q) begin
                state_nxt = STABLE;
                cnt_nxt   = '0;
              end else if (tick) begin
                if (cnt == thresh_m1) begin
                  filt_nxt  = sync_p0;
                  state_nxt = STABLE;
                  cnt_nxt   = '0;
                end else begin
                  cnt_nxt = cnt + CNT_ONE;
                end
              end
            end
            default: begin
              state_nxt = STABLE;
              cnt_nxt   = '0;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  // History / filter stage; dropping i_ie clears filt_q and its delay together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      presc      <= '0;
      mode_q     <= 2'b00;
      state      <= STABLE;
      cnt        <= '0;
      filt_q     <= 1'b0;
      filt_q_d   <= 1'b0;
      sync_d1_p1 <= 1'b0;
      sync_d2_p2 <= 1'b0;
    end else begin
      presc  <= presc + PRESC_WIDTH'(1);
      mode_q <= i_filt_mode;
      if (!i_ie) begin
        state      <= STABLE;
        cnt        <= '0;
        filt_q     <= 1'b0;
        filt_q_d   <= 1'b0;
        sync_d1_p1 <= 1'b0;
        sync_d2_p2 <= 1'b0;
      end else begin
        state      <= state_nxt;
        cnt        <= cnt_nxt;
        filt_q     <= filt_nxt;
        filt_q_d   <= filt_q;
        sync_d1_p1 <= sync_p0;
        sync_d2_p2 <= sync_d1_p1;
      end
    end
  end

  assign o_gpio_in   = filt_q;
  assign o_rise_evt  = i_ie & filt_q & ~filt_q_d;
  assign o_fall_evt  = i_ie & ~filt_q & filt_q_d;
  assign o_filt_busy = (state == COUNT);

  always_comb begin
    for (int i = 0; i < O_NUM_PERIPHERALS; i++) begin
      o_peripheral_in[i] = (i_infunc_en[i] & i_ie) ? filt_q : i_safeval[i];
    end
  end

endmodule

// File: tb/tb_pinmux_input_filter_demux.sv
// Scoreboard bench for pinmux_input_filter_demux: a cycle model pushes the
// expected outputs per clock, popped and compared one step after the edge.
module tb_pinmux_input_filter_demux;

  localparam int NP = 4;
  localparam int SS = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pad = 1'b0;
  logic          ie  = 1'b0;
  logic [1:0]    filt_mode = 2'b00;
  logic [1:0]    deb_sel = 2'b00;
  logic [CW-1:0] deb_thresh = 8'd1;
  logic [NP-1:0] en = '0;
  logic [NP-1:0] safe = '0;
  logic          inv = 1'b0;

  logic [NP-1:0] peripheral_in;
  logic          gpio_in, rise_evt, fall_evt, filt_busy;

  pinmux_input_filter_demux #(
    .O_NUM_PERIPHERALS(NP),
    .SYNC_STAGES      (SS),
    .DEB_CNT_WIDTH    (CW)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_pad_in       (pad),
    .i_ie           (ie),
    .i_filt_mode    (filt_mode),
    .i_deb_clk_sel  (deb_sel),
    .i_deb_thresh   (deb_thresh),
    .i_infunc_en    (en),
    .i_safeval      (safe),
`ifdef PINMUX_IN_INVERT_EN
    .i_invert       (inv),
`endif
    .o_peripheral_in(peripheral_in),
    .o_gpio_in      (gpio_in),
    .o_rise_evt     (rise_evt),
    .o_fall_evt     (fall_evt),
    .o_filt_busy    (filt_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          gpio;
    logic          rise;
    logic          fall;
    logic          busy;
    logic [NP-1:0] per;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state
  logic [SS-1:0] m_s;
  logic          m_d1, m_d2, m_filt, m_filtd, m_busy, m_inv;
  int            m_cnt;
  logic [1:0]    m_mode;
  logic [5:0]    m_presc;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_s = '0; m_d1 = 0; m_d2 = 0; m_filt = 0; m_filtd = 0; m_busy = 0;
    m_inv = 0; m_cnt = 0; m_mode = 2'b00; m_presc = '0;
  endtask

  // Advance the model by one clock using the inputs currently driven,
  // queue the expectation, clock the DUT and compare.
  task automatic step();
    exp_t     e, got;
    logic     sy, tick, chg, nf, nb;
    logic [5:0] mask;
    int       th, nc;
    if (rst) begin
      model_reset();
    end else begin
      mask = 6'((1 << (2 * deb_sel)) - 1);
      tick = ((m_presc & mask) == mask);
      sy   = m_s[SS-1] ^ inv;
      chg  = (filt_mode != m_mode) || (inv != m_inv);
      th   = (deb_thresh == 0) ? 1 : int'(deb_thresh);
      m_presc = m_presc + 6'd1;
      m_mode  = filt_mode;
      m_inv   = inv;
      if (!ie) begin
        m_s = '0; m_d1 = 0; m_d2 = 0; m_filt = 0; m_filtd = 0; m_busy = 0; m_cnt = 0;
      end else begin
        nf = m_filt; nb = 0; nc = 0;
        if (!chg) begin
          case (filt_mode)
            2'b00: nf = sy;
            2'b01: if (sy == m_d1) nf = sy;
            2'b10: if (sy == m_d1 && sy == m_d2) nf = sy;
            default: begin
              nb = m_busy; nc = m_cnt;
              if (!m_busy) begin
                if (sy != m_filt) begin nb = 1; nc = 0; end
              end else if (sy == m_filt) begin
                nb = 0; nc = 0;
              end else if (tick) begin
                if (m_cnt == th - 1) begin nf = sy; nb = 0; nc = 0; end
                else nc = m_cnt + 1;
              end
            end
          endcase
        end
        m_filtd = m_filt; m_filt = nf; m_busy = nb; m_cnt = nc;
        m_d2 = m_d1; m_d1 = sy;
        for (int i = SS - 1; i > 0; i--) m_s[i] = m_s[i-1];
        m_s[0] = pad;
      end
    end
    e.gpio = m_filt;
    e.rise = ie & m_filt & ~m_filtd;
    e.fall = ie & ~m_filt & m_filtd;
    e.busy = m_busy;
    for (int i = 0; i < NP; i++) e.per[i] = (en[i] & ie) ? m_filt : safe[i];
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got.gpio = gpio_in; got.rise = rise_evt; got.fall = fall_evt;
    got.busy = filt_busy; got.per = peripheral_in;
    e = exp_q.pop_front();
    chk("gpio_in", got.gpio, e.gpio);
    chk("rise_evt", got.rise, e.rise);
    chk("fall_evt", got.fall, e.fall);
    chk("filt_busy", got.busy, e.busy);
    chk("peripheral_in", got.per, e.per);
  endtask

  int lat, rises, falls, busy_seen, hi_seen;

  initial begin
    model_reset();
    en = 4'b0101; safe = 4'b1010;
    rst = 1;
    repeat (3) step();
    chk("rst_gpio", gpio_in, 0);
    chk("rst_busy", filt_busy, 0);
    rst = 0; ie = 1; filt_mode = 2'b00;

    // Bypass latency and single rise pulse
    repeat (10) step();
    pad = 1; lat = 0; rises = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (gpio_in && lat == 0) lat = k;
      if (rise_evt) rises++;
    end
    chk("byp_latency", lat, 3);
    chk("byp_rise_count", rises, 1);
    chk("dmx_filt1", peripheral_in, 4'b1111);
    pad = 0;
    repeat (5) step();
    chk("dmx_filt0", peripheral_in, 4'b1010);

    // Dropping i_ie while the level is high must not create a fall event
    pad = 1;
    repeat (5) step();
    ie = 0; falls = 0;
    step();
    if (fall_evt) falls++;
    chk("ie_off_gpio", gpio_in, 0);
    chk("ie_off_dmx", peripheral_in, 4'b1010);
    repeat (3) begin step(); if (fall_evt) falls++; end
    chk("ie_off_no_fall", falls, 0);
    ie = 1; pad = 0;
    repeat (4) step();

    // 3-sample: 2-cycle pulse rejected, 3-cycle pulse accepted
    filt_mode = 2'b10;
    repeat (6) step();
    hi_seen = 0;
    pad = 1; repeat (2) begin step(); if (gpio_in) hi_seen = 1; end
    pad = 0; repeat (8) begin step(); if (gpio_in) hi_seen = 1; end
    chk("3s_reject", hi_seen, 0);
    rises = 0; falls = 0; hi_seen = 0;
    pad = 1; repeat (3) begin step(); hi_seen |= gpio_in; rises += rise_evt; falls += fall_evt; end
    pad = 0; repeat (8) begin step(); hi_seen |= gpio_in; rises += rise_evt; falls += fall_evt; end
    chk("3s_accept", hi_seen, 1);
    chk("3s_rise", rises, 1);
    chk("3s_fall", falls, 1);

    // Debounce: tick every 4 clocks, 3 ticks to accept
    filt_mode = 2'b11; deb_sel = 2'd1; deb_thresh = 8'd3;
    repeat (6) step();
    pad = 1; busy_seen = 0;
    repeat (30) begin step(); busy_seen |= filt_busy; end
    chk("deb_busy_seen", busy_seen, 1);
    chk("deb_accept", gpio_in, 1);
    pad = 0; repeat (6) step();
    pad = 1; repeat (12) step();
    chk("deb_reject_gpio", gpio_in, 1);
    chk("deb_reject_idle", filt_busy, 0);

    // Reset aborts a long count
    deb_sel = 2'd0; deb_thresh = 8'd200;
    pad = 0; repeat (10) step();
    chk("deb_counting", filt_busy, 1);
    rst = 1; step();
    chk("rst_mid_busy", filt_busy, 0);
    chk("rst_mid_gpio", gpio_in, 0);
    rst = 0;

`ifdef PINMUX_IN_INVERT_EN
    filt_mode = 2'b00; inv = 1; pad = 0;
    repeat (8) step();
    chk("invert_gpio", gpio_in, 1);
    inv = 0;
    repeat (4) step();
`endif

    // Randomised traffic against the model
    deb_thresh = 8'd2;
    for (int k = 0; k < 400; k++) begin
      pad = $urandom_range(0, 3) != 0 ? pad : ~pad;
      if ($urandom_range(0, 39) == 0) filt_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) deb_sel = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 59) == 0) deb_thresh = 8'($urandom_range(0, 3));
      ie   = $urandom_range(0, 29) != 0;
      en   = 4'($urandom_range(0, 15));
      safe = 4'($urandom_range(0, 15));
      rst  = $urandom_range(0, 199) == 0;
      step();
    end
    rst = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pinmux_input_filter_demux.md
Name: pinmux_input_filter_demux

Overview:
- Pad-to-peripheral input datapath of a pinmux cell. Complements the output mux and output-enable path.
- Synchronizes the raw pad level, then applies a selectable glitch filter or debounce.
- Produces a filtered GPIO level plus single-cycle edge events.
- Fans the filtered level out to peripheral inputs through per-function enables; a disabled function receives its safe value.

Parameters:
- O_NUM_PERIPHERALS, 4, number of peripheral input functions fed from this pad.
- SYNC_STAGES, 2, synchronizer depth; minimum 2.
- DEB_CNT_WIDTH, 8, width of the debounce threshold and counter.

Ports:
- i_clk  in  1  sole clock.
- i_rst  in  1  reset, synchronous and active-high.
- i_pad_in  in  1  raw pad level, asynchronous to i_clk.
- i_ie  in  1  input enable; 0 gates the whole path.
- i_filt_mode  in  2  00 bypass, 01 2-sample, 10 3-sample, 11 debounce.
- i_deb_clk_sel  in  2  debounce tick period of 1, 4, 16 or 64 clocks (sel 0..3).
- i_deb_thresh  in  DEB_CNT_WIDTH  consecutive ticks required to accept a change; 0 is treated as 1.
- i_infunc_en  in  O_NUM_PERIPHERALS  per-peripheral input-function enable.
- i_safeval  in  O_NUM_PERIPHERALS  value driven to each disabled peripheral.
- o_peripheral_in  out  O_NUM_PERIPHERALS  level delivered to each peripheral.
- o_gpio_in  out  1  filtered pad level.
- o_rise_evt  out  1  one-cycle pulse on a filtered 0->1 transition.
- o_fall_evt  out  1  one-cycle pulse on a filtered 1->0 transition.
- o_filt_busy  out  1  high while debounce is counting.

Behaviour:
- Reset: all flops go to 0.
  - o_gpio_in=0, events=0, o_filt_busy=0.
  - o_peripheral_in follows the combinational rule below from filt_q=0.
- Synchronizer: s[0] <= i_pad_in & i_ie, shifted through SYNC_STAGES flops; sync = last stage.
- History: sync_d1 and sync_d2 keep the previous two sync values.
- Filter register filt_q drives o_gpio_in.
- Bypass: filt_q <= sync. Pad-to-o_gpio_in latency is SYNC_STAGES+1 clocks.
- 2-sample: filt_q <= sync only when sync==sync_d1; otherwise filt_q holds.
- 3-sample: filt_q <= sync only when sync==sync_d1==sync_d2; otherwise filt_q holds.
- Debounce prescaler: free-running 6-bit counter. tick=1 when its low 2*sel bits are all 1; sel=0 gives a tick every cycle.
- Debounce FSM states: STABLE, COUNT.
  - STABLE: if sync!=filt_q, go to COUNT with cnt<=0.
  - COUNT, sync==filt_q: return to STABLE with cnt<=0; the glitch is rejected and filt_q is unchanged.
  - COUNT, sync!=filt_q and tick: if cnt==max(thresh,1)-1, then filt_q<=sync and go to STABLE; else cnt<=cnt+1.
  - cnt never wraps.
- o_filt_busy = (state==COUNT).
- i_filt_mode change in any cycle: FSM goes to STABLE, cnt<=0, filt_q is retained. The new mode takes effect on the next cycle.
- i_ie=0:
  - Synchronizer, history, FSM and cnt are cleared.
  - filt_q<=0 and filt_q_d<=0 together, so no fall event is generated.
  - Events are forced to 0 while i_ie=0.
- Events:
  - rise = filt_q & ~filt_q_d; fall = ~filt_q & filt_q_d.
  - filt_q_d is a one-cycle delay of filt_q.
  - Each event lasts exactly one cycle.
- Demux (combinational from registers): o_peripheral_in[i] = (i_infunc_en[i] & i_ie) ? filt_q : i_safeval[i].
  - Several enables may be set at once; all enabled peripherals see the same level.
- i_rst asserted mid-debounce: the count is aborted and all state returns to reset values on the next edge.

Optional Feature:
- Macro: PINMUX_IN_INVERT_EN.
- Defined: adds input port i_invert (1 bit). sync is XORed with i_invert before the history registers and filter.
  - Toggling i_invert is a mode change: the FSM returns to STABLE and cnt<=0.
- Undefined: i_invert does not exist and no inversion logic is built.

Decomposition:
- Package pinmux_in_pkg holds:
  - filt_mode_e enum: FILT_BYPASS=2'b00, FILT_2S=2'b01, FILT_3S=2'b10, FILT_DEB=2'b11.
  - deb_state_e enum: STABLE, COUNT.
  - PRESC_WIDTH=6.
- Sub-module pinmux_in_sync: parameterized SYNC_STAGES flop chain with synchronous clear. It is instantiated once; the filter, FSM and demux stay in the top.

Test Plan:
- Bypass, SYNC_STAGES=2, i_ie=1, pad 0->1 at cycle 10 -> o_gpio_in=1 at cycle 13; o_rise_evt high at cycle 13 only.
- 3-sample mode, 2-cycle high pulse on pad -> o_gpio_in stays 0, no events. 3-cycle high pulse -> o_gpio_in=1 for 1+ cycles, with rise and fall events.
- Debounce, sel=1, thresh=3, pad held high -> o_filt_busy=1 and o_gpio_in rises after 3 ticks (about 12 clocks). A 2-tick pulse is rejected and o_filt_busy returns to 0.
- Demux: i_infunc_en=4'b0101, i_safeval=4'b1010, filt_q=1 -> o_peripheral_in=4'b1111. With filt_q=0 -> 4'b1010. With i_ie=0 -> 4'b1010.
- i_ie dropped while o_gpio_in=1 -> o_gpio_in=0 next cycle, o_fall_evt never asserts.
- i_rst asserted mid-COUNT with thresh=200 -> next cycle o_filt_busy=0, cnt=0, o_gpio_in=0. With PINMUX_IN_INVERT_EN and i_invert=1, pad low gives o_gpio_in=1.
